fp_result_convert_sp: RTL and testbench
=======================================

Name: fp_result_convert_sp

Overview:
- Downstream stage of the single-precision FP div/sqrt unit.
- Accepts FloPoCo-format results (34 bit, {exc[1:0], sign, exp[7:0], frac[22:0]}) with id and operand-class sideband.
- Converts each result to IEEE-754 binary32, computes fflags and buffers results in a 2-entry FIFO.
- Presents results to FP writeback with a done/ack handshake.

Parameters:
- ID_WIDTH, 3, width of the instruction id carried with each result.
- DEPTH, 2, FIFO entries; only the value 2 is supported.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- in_done  in  1  upstream result valid.
- in_ack  out  1  upstream result accepted this cycle.
- in_rd  in  34  FloPoCo result.
- in_id  in  ID_WIDTH  instruction id.
- in_sqrt  in  1  1 = sqrt op, 0 = div op.
- in_a_exc  in  2  FloPoCo class of operand A.
- in_b_exc  in  2  FloPoCo class of operand B; ignored for sqrt.
- out_done  out  1  result valid to writeback.
- out_ack  in  1  writeback consumed result.
- out_rd  out  32  IEEE binary32 result.
- out_id  out  ID_WIDTH  instruction id.
- out_fflags  out  5  {NV,DZ,OF,UF,NX}.

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO emptied; out_done=0, in_ack=1.
  - out_rd, out_id and out_fflags are 0.
  - In-flight entries are discarded.
- Handshakes:
  - Input transfer occurs when in_done && in_ack.
  - Output transfer occurs when out_done && out_ack.
  - in_ack = !full, from registered state only; there is no combinational path from out_ack.
- Latency and throughput:
  - An accepted result appears on out_* the next cycle when the FIFO was empty.
  - Sustained throughput is 1 result/cycle.
- Simultaneous events:
  - Push and pop in the same cycle keep occupancy unchanged.
  - At full with out_ack=1, in_ack stays 0 in that cycle and rises the following cycle.
- Ordering: strict FIFO; out_* is stable while out_done && !out_ack.
- Conversion (combinational, before FIFO write):
  - exc=00 → {sign, 31'b0}.
  - exc=10 → {sign, 8'hFF, 23'b0}.
  - exc=11 → canonical NaN 32'h7FC00000.
  - exc=01, exp≥1 → {sign, exp, frac}.
  - exc=01, exp=0 (value 2^-127·1.f) → subnormal path, see Optional Feature.
- Flags:
  - NV: result NaN and neither operand class NaN; B is excluded for sqrt.
  - DZ: div, b_exc=00, a_exc=01.
  - OF: result inf, !DZ, a_exc≠10 and (sqrt or b_exc≠10); when OF is set, NX is also set.
  - UF and NX on the subnormal path are set per Optional Feature; all other cases are 0.

Optional Feature:
- Macro: FP_SUBNORMAL_EN.
- Defined:
  - Subnormal path yields frac' = {1, frac[22:1]}, rounded to nearest-even on the lost bit frac[0].
  - Increment when frac[0] && frac[1]; carry into exp=1 is legal.
  - NX = UF = frac[0].
- Undefined: subnormal path flushes to {sign, 31'b0} with UF=1, NX=1.

Decomposition:
- fpu package holds:
  - fp_exc_t enum (ZERO=00, NORMAL=01, INF=10, NAN=11).
  - fflags_t packed struct {nv,dz,of,uf,nx}.
  - CANONICAL_NAN_SP = 32'h7FC00000.
  - Existing flopoco_t.
- Sub-module fp_flopoco_to_ieee_sp: purely combinational conversion plus flag logic. The top level holds the FIFO and handshakes.

Test Plan:
- Reset behaviour: assert rst low mid-burst with 2 entries queued → out_done=0 immediately; after release in_ack=1, no stale result emitted.
- Basic conversion and latency: in_rd={01,0,8'h7F,0}, in_id=5, out_ack=1 → next cycle out_rd=32'h3F800000, out_id=5, fflags=0.
- Flag generation, div by zero: div, a_exc=01, b_exc=00, in_rd exc=10, sign 1 → out_rd=32'hFF800000, fflags=5'b01000.
- Flag generation, invalid ops:
  - sqrt with a_exc=01, in_rd exc=11 → 32'h7FC00000, fflags=5'b10000.
  - div with a_exc=11 → fflags=0.
- Subnormal path: in_rd={01,0,8'h00,23'h000003}:
  - FP_SUBNORMAL_EN defined → out_rd=32'h00400002, fflags=5'b00011.
  - FP_SUBNORMAL_EN undefined → 32'h00000000, fflags=5'b00011.
- Backpressure and ordering: out_ack=0, push ids 1,2 → in_ack=0. Then raise out_ack with in_done=1 id 3 → id1 out, in_ack rises next cycle, order 1,2,3 preserved.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types for the single-precision FP div/sqrt datapath.
// FloPoCo result layout, operand classes, exception flags and the canonical NaN.
package fpu_pkg;

  typedef enum logic [1:0] {
    ZERO   = 2'b00,
    NORMAL = 2'b01,
    INF    = 2'b10,
    NAN    = 2'b11
  } fp_exc_t;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef struct packed {
    fp_exc_t     exc;
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } flopoco_t;

  localparam logic [31:0] CANONICAL_NAN_SP = 32'h7FC0_0000;

endpackage

// File: rtl/fp_flopoco_to_ieee_sp.sv
// Combinational FloPoCo -> IEEE-754 binary32 conversion with fflags generation.
// Build option FP_SUBNORMAL_EN: keep 2^-127 results as rounded subnormals instead of flushing to zero.
module fp_flopoco_to_ieee_sp
  import fpu_pkg::*;
(
  input  flopoco_t    rd,
  input  logic        sqrt,
  input  fp_exc_t     a_exc,
  input  fp_exc_t     b_exc,
  output logic [31:0] ieee,
  output fflags_t     fflags
);

  logic div_by_zero;
  assign div_by_zero = !sqrt && (b_exc == ZERO) && (a_exc == NORMAL);

`ifdef FP_SUBNORMAL_EN
  // Exponent 0 means 2^-127 * 1.f, i.e. 0.1f x 2^-126: shift the hidden one in,
  // round to nearest-even on the dropped bit. A carry out lands in exp=1 correctly.
  logic [23:0] sub_sum;
  assign sub_sum = {1'b0, 1'b1, rd.frac[22:1]} + 24'(rd.frac[0] & rd.frac[1]);
`endif

  always_comb begin
    // NOTE: every output is defaulted before the case so no branch can infer a latch.
    ieee      = '0;
    fflags    = '0;
    fflags.dz = div_by_zero;
    unique case (rd.exc)
      ZERO: ieee = {rd.sign, 31'b0};
      INF: begin
        ieee      = {rd.sign, 8'hFF, 23'b0};
        fflags.of = !div_by_zero && (a_exc != INF) && (sqrt || (b_exc != INF));
        fflags.nx = fflags.of;
      end
      NAN: begin
        ieee      = CANONICAL_NAN_SP;
        fflags.nv = (a_exc != NAN) && (sqrt || (b_exc != NAN));
      end
      NORMAL: begin
        if (rd.exp != 8'd0) begin
          ieee = {rd.sign, rd.exp, rd.frac};
        end else begin
`ifdef FP_SUBNORMAL_EN
          ieee      = {rd.sign, 7'b0, sub_sum};
          fflags.uf = rd.frac[0];
          fflags.nx = rd.frac[0];
`else
          ieee      = {rd.sign, 31'b0};
          fflags.uf = 1'b1;
          fflags.nx = 1'b1;
`endif
        end
      end
      default: ieee = '0;
    endcase
  end

endmodule

// File: rtl/fp_result_convert_sp.sv
// Result stage of the SP div/sqrt unit: converts to binary32, buffers in a 2-entry FIFO,
// and hands results to writeback with done/ack. Build option FP_SUBNORMAL_EN (see converter).
module fp_result_convert_sp
  import fpu_pkg::*;
#(
  parameter int ID_WIDTH = 3,
  parameter int DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_done,
  output logic                in_ack,
  input  logic [33:0]         in_rd,
  input  logic [ID_WIDTH-1:0] in_id,
  input  logic                in_sqrt,
  input  logic [1:0]          in_a_exc,
  input  logic [1:0]          in_b_exc,
  output logic                out_done,
  input  logic                out_ack,
  output logic [31:0]         out_rd,
  output logic [ID_WIDTH-1:0] out_id,
  output logic [4:0]          out_fflags
);

  // Pointer wrap relies on DEPTH being a power of two; only 2 is supported.
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0] conv_rd;
  fflags_t     conv_flags;

  fp_flopoco_to_ieee_sp u_conv (
    .rd     (flopoco_t'(in_rd)),
    .sqrt   (in_sqrt),
    .a_exc  (fp_exc_t'(in_a_exc)),
    .b_exc  (fp_exc_t'(in_b_exc)),
    .ieee   (conv_rd),
    .fflags (conv_flags)
  );

  logic [31:0]         rd_mem [DEPTH];
  logic [ID_WIDTH-1:0] id_mem [DEPTH];
  fflags_t             fl_mem [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;

  // Handshake depends on registered occupancy only, never on out_ack.
  assign in_ack   = (count != CW'(DEPTH));
  assign out_done = (count != '0);
  assign push     = in_done && in_ack;
  assign pop      = out_done && out_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; outputs are masked by out_done, so stale entries never leak.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr] <= conv_rd;
      id_mem[wr_ptr] <= in_id;
      fl_mem[wr_ptr] <= conv_flags;
    end
  end

  assign out_rd     = out_done ? rd_mem[rd_ptr] : '0;
  assign out_id     = out_done ? id_mem[rd_ptr] : '0;
  assign out_fflags = out_done ? fl_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_fp_result_convert_sp.sv
// Directed self-checking bench for fp_result_convert_sp (honours FP_SUBNORMAL_EN).
module tb_fp_result_convert_sp;

  localparam int IDW = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_done = 1'b0;
  logic           in_ack;
  logic [33:0]    in_rd = '0;
  logic [IDW-1:0] in_id = '0;
  logic           in_sqrt = 1'b0;
  logic [1:0]     in_a_exc = 2'b01;
  logic [1:0]     in_b_exc = 2'b01;
  logic           out_done;
  logic           out_ack = 1'b0;
  logic [31:0]    out_rd;
  logic [IDW-1:0] out_id;
  logic [4:0]     out_fflags;

  int tests_run = 0;
  int tests_failed = 0;

  fp_result_convert_sp #(.ID_WIDTH(IDW), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst_n),
    .in_done    (in_done),
    .in_ack     (in_ack),
    .in_rd      (in_rd),
    .in_id      (in_id),
    .in_sqrt    (in_sqrt),
    .in_a_exc   (in_a_exc),
    .in_b_exc   (in_b_exc),
    .out_done   (out_done),
    .out_ack    (out_ack),
    .out_rd     (out_rd),
    .out_id     (out_id),
    .out_fflags (out_fflags)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic send(input logic [33:0] rd, input logic [IDW-1:0] id,
                      input logic sqrt, input logic [1:0] a, input logic [1:0] b);
    in_done = 1'b1; in_rd = rd; in_id = id; in_sqrt = sqrt; in_a_exc = a; in_b_exc = b;
    @(posedge clk);
    @(negedge clk);
    in_done = 1'b0;
  endtask

  // Push one result into an empty FIFO and check it on the next cycle, then drain it.
  task automatic one_shot(input string name, input logic [33:0] rd, input logic sqrt,
                          input logic [1:0] a, input logic [1:0] b, input logic [IDW-1:0] id,
                          input logic [31:0] exp_rd, input logic [4:0] exp_fl);
    out_ack = 1'b1;
    send(rd, id, sqrt, a, b);
    tests_run++;
    if ({out_done, out_rd, out_id, out_fflags} !== {1'b1, exp_rd, id, exp_fl}) begin
      tests_failed++;
      $display("FAIL %s: got done=%b rd=%h id=%0d fflags=%b, expected done=1 rd=%h id=%0d fflags=%b",
               name, out_done, out_rd, out_id, out_fflags, exp_rd, id, exp_fl);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    tests_run++;
    if ({out_done, in_ack, out_rd, out_id, out_fflags} !== {1'b0, 1'b1, 32'h0, 3'h0, 5'h0}) begin
      tests_failed++;
      $display("FAIL reset_state: got done=%b ack=%b rd=%h id=%0d fl=%b, expected 0 1 0 0 0",
               out_done, in_ack, out_rd, out_id, out_fflags);
    end
    out_ack = 1'b0;
    send({2'b01, 1'b0, 8'h7F, 23'h0}, 3'd6, 1'b0, 2'b01, 2'b01);
    send({2'b01, 1'b0, 8'h80, 23'h0}, 3'd7, 1'b0, 2'b01, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_done, in_ack, out_rd, out_id, out_fflags} !== {1'b0, 1'b1, 32'h0, 3'h0, 5'h0}) begin
      tests_failed++;
      $display("FAIL reset_midburst: got done=%b ack=%b rd=%h id=%0d fl=%b, expected 0 1 0 0 0",
               out_done, in_ack, out_rd, out_id, out_fflags);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if ({out_done, in_ack} !== 2'b01) begin
        tests_failed++;
        $display("FAIL reset_no_stale: cycle %0d got done=%b ack=%b, expected done=0 ack=1",
                 i, out_done, in_ack);
      end
    end
  endtask

  task automatic test_basic;
    one_shot("basic_one", {2'b01, 1'b0, 8'h7F, 23'h0}, 1'b0, 2'b01, 2'b01, 3'd5, 32'h3F80_0000, 5'b00000);
    one_shot("basic_neg", {2'b01, 1'b1, 8'h80, 23'h40_0000}, 1'b0, 2'b01, 2'b01, 3'd2, 32'hC040_0000, 5'b00000);
    one_shot("zero_neg", {2'b00, 1'b1, 8'h00, 23'h0}, 1'b0, 2'b01, 2'b01, 3'd1, 32'h8000_0000, 5'b00000);
  endtask

  task automatic test_div_by_zero;
    one_shot("div_by_zero", {2'b10, 1'b1, 8'h00, 23'h0}, 1'b0, 2'b01, 2'b00, 3'd3, 32'hFF80_0000, 5'b01000);
    one_shot("overflow", {2'b10, 1'b0, 8'h00, 23'h0}, 1'b0, 2'b01, 2'b01, 3'd4, 32'h7F80_0000, 5'b00101);
    one_shot("inf_operand", {2'b10, 1'b0, 8'h00, 23'h0}, 1'b0, 2'b10, 2'b01, 3'd0, 32'h7F80_0000, 5'b00000);
  endtask

  task automatic test_invalid;
    one_shot("sqrt_invalid", {2'b11, 1'b0, 8'h00, 23'h0}, 1'b1, 2'b01, 2'b11, 3'd6, 32'h7FC0_0000, 5'b10000);
    one_shot("div_nan_in", {2'b11, 1'b0, 8'h00, 23'h0}, 1'b0, 2'b11, 2'b01, 3'd7, 32'h7FC0_0000, 5'b00000);
    one_shot("zero_div_zero", {2'b11, 1'b0, 8'h00, 23'h0}, 1'b0, 2'b00, 2'b00, 3'd1, 32'h7FC0_0000, 5'b10000);
  endtask

  task automatic test_subnormal;
`ifdef FP_SUBNORMAL_EN
    one_shot("sub_round_up", {2'b01, 1'b0, 8'h00, 23'h00_0003}, 1'b0, 2'b01, 2'b01, 3'd2, 32'h0040_0002, 5'b00011);
    one_shot("sub_tie_even", {2'b01, 1'b0, 8'h00, 23'h00_0001}, 1'b0, 2'b01, 2'b01, 3'd3, 32'h0040_0000, 5'b00011);
    one_shot("sub_exact", {2'b01, 1'b0, 8'h00, 23'h00_0002}, 1'b0, 2'b01, 2'b01, 3'd4, 32'h0040_0001, 5'b00000);
    one_shot("sub_carry", {2'b01, 1'b1, 8'h00, 23'h7F_FFFF}, 1'b0, 2'b01, 2'b01, 3'd5, 32'h8080_0000, 5'b00011);
`else
    one_shot("sub_round_up", {2'b01, 1'b0, 8'h00, 23'h00_0003}, 1'b0, 2'b01, 2'b01, 3'd2, 32'h0000_0000, 5'b00011);
    one_shot("sub_tie_even", {2'b01, 1'b0, 8'h00, 23'h00_0001}, 1'b0, 2'b01, 2'b01, 3'd3, 32'h0000_0000, 5'b00011);
    one_shot("sub_exact", {2'b01, 1'b0, 8'h00, 23'h00_0002}, 1'b0, 2'b01, 2'b01, 3'd4, 32'h0000_0000, 5'b00011);
    one_shot("sub_carry", {2'b01, 1'b1, 8'h00, 23'h7F_FFFF}, 1'b0, 2'b01, 2'b01, 3'd5, 32'h8000_0000, 5'b00011);
`endif
  endtask

  task automatic test_backpressure;
    out_ack = 1'b0;
    send({2'b01, 1'b0, 8'h81, 23'h0}, 3'd1, 1'b0, 2'b01, 2'b01);
    send({2'b01, 1'b0, 8'h82, 23'h0}, 3'd2, 1'b0, 2'b01, 2'b01);
    tests_run++;
    if ({in_ack, out_done, out_id, out_rd} !== {1'b0, 1'b1, 3'd1, 32'h4080_0000}) begin
      tests_failed++;
      $display("FAIL bp_full: got ack=%b done=%b id=%0d rd=%h, expected ack=0 done=1 id=1 rd=40800000",
               in_ack, out_done, out_id, out_rd);
    end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({in_ack, out_done, out_id, out_rd} !== {1'b0, 1'b1, 3'd1, 32'h4080_0000}) begin
      tests_failed++;
      $display("FAIL bp_stable: got ack=%b done=%b id=%0d rd=%h, expected ack=0 done=1 id=1 rd=40800000",
               in_ack, out_done, out_id, out_rd);
    end
    out_ack = 1'b1;
    in_done = 1'b1; in_rd = {2'b01, 1'b0, 8'h83, 23'h0}; in_id = 3'd3;
    tests_run++;
    if (in_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_ack_same_cycle: got in_ack=%b, expected 0", in_ack);
    end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({in_ack, out_done, out_id} !== {1'b1, 1'b1, 3'd2}) begin
      tests_failed++;
      $display("FAIL bp_ack_rise: got ack=%b done=%b id=%0d, expected ack=1 done=1 id=2",
               in_ack, out_done, out_id);
    end
    @(posedge clk);
    @(negedge clk);
    in_done = 1'b0;
    tests_run++;
    if ({out_done, out_id, out_rd} !== {1'b1, 3'd3, 32'h4180_0000}) begin
      tests_failed++;
      $display("FAIL bp_order3: got done=%b id=%0d rd=%h, expected done=1 id=3 rd=41800000",
               out_done, out_id, out_rd);
    end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (out_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_drained: got out_done=%b, expected 0", out_done);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] e;
    out_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = 8'h80 + 8'(i);
      in_done = 1'b1; in_rd = {2'b01, 1'b0, e, 23'h0}; in_id = IDW'(i + 4);
      in_sqrt = 1'b0; in_a_exc = 2'b01; in_b_exc = 2'b01;
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if ({in_ack, out_done, out_id, out_rd} !== {1'b1, 1'b1, IDW'(i + 4), 1'b0, e, 23'h0}) begin
        tests_failed++;
        $display("FAIL b2b_%0d: got ack=%b done=%b id=%0d rd=%h, expected ack=1 done=1 id=%0d rd=%h",
                 i, in_ack, out_done, out_id, out_rd, IDW'(i + 4), {1'b0, e, 23'h0});
      end
    end
    in_done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (out_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_drained: got out_done=%b, expected 0", out_done);
    end
  endtask

  initial begin
    #12;
    rst_n = 1'b1;
    @(negedge clk);
    test_reset;
    test_basic;
    test_div_by_zero;
    test_invalid;
    test_subnormal;
    test_backpressure;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
